// File: rtl/wb_dbg_bridge.sv
`default_nettype none
// ============================================================================
// Module  : wb_dbg_bridge
// Purpose : Host byte-stream command frames to single-beat Wishbone cycles,
//           with read data or a status byte returned on the transmit stream.
// Revision: 1.0 - initial release
// ============================================================================
module wb_dbg_bridge #(
  parameter int WB_AW    = 16,
  parameter int BUS_TO_W = 8,
  parameter int RX_TO_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_stb,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ack,
  output logic [WB_AW-1:0] wb_addr,
  output logic [31:0]      wb_wdata,
  output logic [3:0]       wb_wmsk,
  output logic             wb_we,
  output logic             wb_cyc,
  input  logic [31:0]      wb_rdata,
  input  logic             wb_ack,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [3:0]          wmsk_q, wmsk_d;
  logic [WB_AW-1:0]    addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         resp_q, resp_d;
  logic [BUS_TO_W-1:0] bto_q, bto_d;
  logic [RX_TO_W-1:0]  rto_q, rto_d;
  logic                cmd_rd, cmd_wr;

  assign cmd_rd = (rx_data[7:4] == 4'h1);
  assign cmd_wr = (rx_data[7:4] == 4'h2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    wmsk_d  = wmsk_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    bto_d   = '0;
    rto_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (rx_stb && (cmd_rd || cmd_wr)) begin
          we_d    = cmd_wr;
          wmsk_d  = cmd_wr ? rx_data[3:0] : 4'h0;
          addr_d  = '0;
          cnt_d   = 3'd0;
          state_d = S_ADDR;
        end
      end
      S_ADDR, S_DATA: begin
        if (rx_stb) begin
          cnt_d = cnt_q + 3'd1;
          if (state_q == S_ADDR) begin
            // Shifting into a WB_AW-wide register truncates or zero-extends the 16-bit address.
            addr_d = WB_AW'({addr_q, rx_data});
            if (cnt_q == 3'd1) begin
              cnt_d   = 3'd0;
              state_d = we_q ? S_DATA : S_BUS;
            end
          end else begin
            wdata_d = {wdata_q[23:0], rx_data};
            if (cnt_q == 3'd3) state_d = S_BUS;
          end
        end else if (&rto_q) begin
          state_d = S_IDLE;
        end else begin
          rto_d = rto_q + 1'b1;
        end
      end
      S_BUS: begin
        // cnt_q is reused as the number of response bytes still to send.
        if (wb_ack) begin
          resp_d  = we_q ? {8'hAA, 24'h0} : wb_rdata;
          cnt_d   = we_q ? 3'd1 : 3'd4;
          state_d = S_RESP;
        end else if (&bto_q) begin
          resp_d  = {8'hEE, 24'h0};
          cnt_d   = 3'd1;
          state_d = S_RESP;
        end else begin
          bto_d = bto_q + 1'b1;
        end
      end
      S_RESP: begin
        if (tx_ack) begin
          resp_d = {resp_q[23:0], 8'h00};
          cnt_d  = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      wmsk_q  <= 4'h0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      resp_q  <= 32'h0;
      bto_q   <= '0;
      rto_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wmsk_q  <= wmsk_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      bto_q   <= bto_d;
      rto_q   <= rto_d;
    end
  end

  assign wb_cyc   = (state_q == S_BUS);
  assign tx_valid = (state_q == S_RESP);
  assign busy     = (state_q != S_IDLE);
  assign tx_data  = resp_q[31:24];
  assign wb_addr  = addr_q;
  assign wb_wdata = wdata_q;
  assign wb_wmsk  = wmsk_q;
  assign wb_we    = we_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_dbg_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_dbg_bridge
// Purpose : Randomized frame/bus/response bench with a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_dbg_bridge;
  localparam int WB_AW    = 16;
  localparam int BUS_TO_W = 4;
  localparam int RX_TO_W  = 6;
  localparam int BUS_TO   = 1 << BUS_TO_W;
  localparam int RX_TO    = 1 << RX_TO_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       rx_data = 8'h0;
  logic             rx_stb = 1'b0;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ack = 1'b0;
  logic [WB_AW-1:0] wb_addr;
  logic [31:0]      wb_wdata;
  logic [3:0]       wb_wmsk;
  logic             wb_we;
  logic             wb_cyc;
  logic [31:0]      wb_rdata = 32'h0;
  logic             wb_ack = 1'b0;
  logic             busy;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  wb_dbg_bridge #(.WB_AW(WB_AW), .BUS_TO_W(BUS_TO_W), .RX_TO_W(RX_TO_W)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_stb(rx_stb),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_wmsk(wb_wmsk), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_rdata(wb_rdata), .wb_ack(wb_ack), .busy(busy)
  );

  // Bytes sent MSB-first from the low n bytes of 'bytes', one per cycle.
  task automatic send_bytes(input logic [55:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      rx_data = bytes[8*(n-1-i) +: 8];
      rx_stb  = 1'b1;
      @(negedge clk);
    end
    rx_stb = 1'b0;
  endtask

  // Entered one cycle after the last frame byte; runs the slave side and drains the response.
  task automatic bus_and_resp(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                              input logic [3:0] msk, input int ack_idx, input logic [31:0] rd,
                              input int bp, input bit noise);
    logic [7:0] exp_q[$];
    logic [3:0] exp_msk;
    int exp_len, n;
    bit bad;
    exp_msk = wr ? msk : 4'h0;
    exp_len = (ack_idx < BUS_TO) ? ack_idx + 1 : BUS_TO;
    if (ack_idx >= BUS_TO)  exp_q = '{8'hEE};
    else if (wr)            exp_q = '{8'hAA};
    else                    exp_q = '{rd[31:24], rd[23:16], rd[15:8], rd[7:0]};

    total++;
    if (wb_cyc !== 1'b1 || wb_addr !== addr || wb_we !== wr || wb_wmsk !== exp_msk ||
        (wr && wb_wdata !== data)) begin
      $display("FAIL bus_start: cyc=%b addr=%h we=%b msk=%h wdata=%h required cyc=1 addr=%h we=%b msk=%h wdata=%h",
               wb_cyc, wb_addr, wb_we, wb_wmsk, wb_wdata, addr, wr, exp_msk, data);
    end else pass_cnt++;

    n = 0; bad = 1'b0;
    while (wb_cyc === 1'b1 && n < 40) begin
      if (wb_addr !== addr || wb_we !== wr || wb_wmsk !== exp_msk || (wr && wb_wdata !== data)) bad = 1'b1;
      wb_ack   = (n == ack_idx);
      wb_rdata = (n == ack_idx) ? rd : $urandom;
      rx_stb   = noise;
      rx_data  = 8'h10;
      n++;
      @(negedge clk);
    end
    wb_ack = 1'b0; rx_stb = 1'b0;
    total++;
    if (n !== exp_len || bad) begin
      $display("FAIL bus_len: cyc high %0d cycles (unstable=%b) required %0d (stable)", n, bad, exp_len);
    end else pass_cnt++;

    // A stray ack after the cycle has ended must not disturb the response.
    wb_ack = noise; wb_rdata = $urandom;
    foreach (exp_q[i]) begin
      bad = 1'b0;
      for (int c = 0; c < bp; c++) begin
        if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) bad = 1'b1;
        rx_stb = noise; rx_data = 8'h10;
        @(negedge clk);
        wb_ack = 1'b0;
      end
      total++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[i] || bad) begin
        $display("FAIL resp_byte%0d: valid=%b data=%h (held-unstable=%b) required valid=1 data=%h",
                 i, tx_valid, tx_data, bad, exp_q[i]);
      end else pass_cnt++;
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0; wb_ack = 1'b0; rx_stb = 1'b0;
    end
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || wb_cyc !== 1'b0) begin
      $display("FAIL resp_end: valid=%b busy=%b cyc=%b required 0 0 0", tx_valid, busy, wb_cyc);
    end else pass_cnt++;
  endtask

  task automatic do_txn(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                        input logic [3:0] msk, input int ack_idx, input logic [31:0] rd,
                        input int bp, input bit noise);
    logic [7:0] cmd;
    cmd = wr ? {4'h2, msk} : {4'h1, msk};
    if (wr) send_bytes({cmd, addr, data}, 7);
    else    send_bytes({32'h0, cmd, addr}, 3);
    bus_and_resp(wr, addr, data, msk, ack_idx, rd, bp, noise);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (wb_cyc !== 1'b0 || wb_we !== 1'b0 || wb_addr !== '0 || wb_wdata !== 32'h0 ||
        wb_wmsk !== 4'h0 || tx_valid !== 1'b0 || tx_data !== 8'h0 || busy !== 1'b0) begin
      $display("FAIL reset: cyc=%b we=%b addr=%h wdata=%h msk=%h txv=%b txd=%h busy=%b required all zero",
               wb_cyc, wb_we, wb_addr, wb_wdata, wb_wmsk, tx_valid, tx_data, busy);
    end else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    do_txn(1'b0, 16'h0005, 32'h0, 4'h0, 2, 32'hDEADBEEF, 0, 1'b0);
  endtask

  task automatic test_write();
    do_txn(1'b1, 16'h1234, 32'h01020304, 4'h3, 1, 32'h0, 0, 1'b0);
  endtask

  task automatic test_bus_timeout();
    do_txn(1'b0, 16'hBEEF, 32'h0, 4'h0, BUS_TO + 5, 32'h0, 1, 1'b0);
    do_txn(1'b1, 16'h0042, 32'hCAFEF00D, 4'h0, BUS_TO - 1, 32'h0, 0, 1'b0);
    do_txn(1'b0, 16'h0042, 32'h0, 4'h0, 0, 32'h12345678, 0, 1'b0);
  endtask

  task automatic test_framing();
    bit bad;
    send_bytes({48'h0, 8'h7F}, 1);
    total++;
    if (busy !== 1'b0) $display("FAIL bad_opcode: busy=%b required 0", busy);
    else pass_cnt++;

    send_bytes({40'h0, 8'h10, 8'h00}, 2);
    bad = 1'b0;
    for (int c = 0; c < RX_TO; c++) begin
      if (busy !== 1'b1 || wb_cyc !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    total++;
    if (bad || busy !== 1'b0 || wb_cyc !== 1'b0) begin
      $display("FAIL rx_timeout: early-drop/cyc=%b busy=%b cyc=%b required 0 0 0", bad, busy, wb_cyc);
    end else pass_cnt++;
    do_txn(1'b0, 16'h0077, 32'h0, 4'h0, 3, 32'hA5A55A5A, 0, 1'b0);

    // Final byte strobed in the expiry cycle is still accepted.
    send_bytes({40'h0, 8'h10, 8'h00}, 2);
    repeat (RX_TO - 1) @(negedge clk);
    send_bytes({48'h0, 8'h05}, 1);
    bus_and_resp(1'b0, 16'h0005, 32'h0, 4'h0, 1, 32'h0BADCAFE, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_txn(1'b0, 16'h0100, 32'h0, 4'hF, 4, 32'h89ABCDEF, 10, 1'b1);
    do_txn(1'b1, 16'h0200, 32'h55AA55AA, 4'h9, BUS_TO + 1, 32'h0, 10, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 40; t++) begin
      bit wr;
      int ack_idx;
      wr = $urandom_range(0, 1);
      ack_idx = $urandom_range(0, 4) == 0 ? $urandom_range(BUS_TO - 1, BUS_TO + 2)
                                          : $urandom_range(0, 6);
      do_txn(wr, 16'($urandom), $urandom, 4'($urandom), ack_idx, $urandom,
             $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  task automatic test_async_reset();
    send_bytes({32'h0, 8'h10, 16'h0033}, 3);
    repeat (3) @(negedge clk);
    total++;
    if (wb_cyc !== 1'b1) $display("FAIL pre_reset_cyc: cyc=%b required 1", wb_cyc);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (wb_cyc !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL async_reset: cyc=%b txv=%b busy=%b required 0 0 0", wb_cyc, tx_valid, busy);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_txn(1'b1, 16'h0ABC, 32'h11223344, 4'hC, 2, 32'h0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_bus_timeout();
    test_framing();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
`default_nettype wire
